dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port word data memory.
- Shares the memory between the core load/store unit (port C) and a DMA/debug master (port D).
- Uses a req/ack handshake, round-robin fairness, an address-window and alignment check, and a registered read response.
- Sits between the core/DMA masters and the data memory's wr_en/wr_addr/wr_data/rd_data_mem port.

Parameters:
- DATA_WIDTH, 32, data word width.
- ADDR_WIDTH, 32, byte address width.
- DMEM_BASE, 32'h02000000, lowest legal data-memory byte address; lower addresses are rejected.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- c_req  input  1  core request; held high until c_ack.
- c_we  input  1  core write (1) / read (0).
- c_addr  input  ADDR_WIDTH  core byte address.
- c_wdata  input  DATA_WIDTH  core write data.
- c_ack  output  1  one-cycle completion pulse.
- c_err  output  1  valid with c_ack; access rejected.
- c_rdata  output  DATA_WIDTH  read data, valid with c_ack.
- d_req, d_we, d_addr, d_wdata, d_ack, d_err, d_rdata  same as the c_* ports, for the DMA port.
- mem_wr_en  output  1  to memory wr_en.
- mem_addr  output  ADDR_WIDTH  to memory wr_addr.
- mem_wr_data  output  DATA_WIDTH  to memory wr_data.
- mem_rd_data  input  DATA_WIDTH  from memory rd_data_mem (combinational read).
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low.
- Reset values: all outputs 0, FSM = IDLE, round-robin pointer = core-preferred.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Samples c_req and d_req.
  - Only one asserted: grant it.
  - Both asserted: grant the port the pointer prefers, then flip the pointer to the other port.
  - A single grant moves the pointer to prefer the non-granted port.
  - On grant, latch we/addr/wdata plus a port id into internal registers.
  - Compute err = (addr < DMEM_BASE) or (addr[1:0] != 0).
  - Go to ACCESS. With no request, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - If err=0: mem_addr = latched addr; mem_wr_data = latched wdata; mem_wr_en = latched we.
  - If err=1: mem_wr_en = 0 and mem_addr = 0, so the memory sees no access.
  - At the closing edge, capture mem_rd_data into the granted port's rdata register for a read without error. The write commits at the same edge.
  - Go to RESP.
- RESP (1 cycle):
  - Granted port's ack = 1, err = latched err.
  - rdata = captured word for a read; 0 for a write or on error.
  - The non-granted port's ack, err and rdata stay 0.
  - Go to IDLE.
- Outside ACCESS: mem_wr_en = 0 and mem_addr = 0.
- Latency: request seen in IDLE at cycle N; ack high in cycle N+2. Maximum throughput is one access per 3 cycles.
- Handshake:
  - Inputs are sampled only in IDLE. Requesters must hold req and payload stable until ack.
  - A requester drops req, or presents the next transaction, at the edge where ack is sampled.
  - req high in the IDLE cycle after ack counts as a new transaction.
- Starvation bound: with both ports requesting continuously, grants alternate C, D, C, D. The wait for either port is at most 6 cycles.
- rdata and err hold their value until the next RESP for that port. Only ack is a pulse.
- The arbiter passes addresses through unmodified. Memory-side wrap (word index modulo depth) belongs to the memory.
- Reset mid-operation (rst_n low during ACCESS) asynchronously drops mem_wr_en, so no write commits. The aborted transaction gets no ack.
- After reset the pointer is core-preferred: simultaneous first requests grant C.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- When defined, add outputs perf_c_grants[15:0], perf_d_grants[15:0] and perf_conflicts[15:0].
  - perf_c_grants / perf_d_grants increment on each IDLE grant to that port.
  - perf_conflicts increments on each IDLE cycle where both reqs are high.
  - Counters are saturating, cleared by rst_n and by input perf_clr (synchronous, priority over increment).
- When undefined, these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset, then c_req with c_we=1, c_addr=32'h02000010, c_wdata=32'hDEADBEEF -> mem_wr_en=1 with mem_addr=32'h02000010 in cycle N+1; c_ack=1, c_err=0 in cycle N+2; d_ack stays 0.
- Core read of 32'h02000010 after that write -> c_ack in cycle N+2 with c_rdata=32'hDEADBEEF.
- c_req and d_req asserted together, held continuously, 4 transactions each -> grant order C,D,C,D,C,D,C,D; each ack 3 cycles apart.
- d_req write to 32'h00001000 -> mem_wr_en never asserts; d_ack=1, d_err=1, d_rdata=0.
- c_req read of 32'h02000002 (misaligned) -> c_err=1 with c_ack; no memory access.
- Write request, rst_n pulsed low during ACCESS -> mem_wr_en falls immediately, read-back after reset does not return the write data, no ack issued.
- With DMEM_ARB_PERF_EN: the 4+4 contention scenario -> perf_c_grants=4, perf_d_grants=4, perf_conflicts>=7; perf_clr -> all counters 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin req/ack arbiter and sequencer sharing one data-memory port between
// the core (C) and DMA (D) masters. Define DMEM_ARB_PERF_EN to add grant/conflict counters.
module dmem_arbiter #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] DMEM_BASE  = 32'h02000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    output logic                  c_ack,
    output logic                  c_err,
    output logic [DATA_WIDTH-1:0] c_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic                  d_err,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  busy,
`ifdef DMEM_ARB_PERF_EN
    input  logic                  perf_clr,
    output logic [15:0]           perf_c_grants,
    output logic [15:0]           perf_d_grants,
    output logic [15:0]           perf_conflicts,
`endif
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state_q;
    logic                  ptr_q;      // 1: D is preferred on the next conflict
    logic                  port_q;     // 1: D holds the current grant
    logic                  we_q;
    logic                  err_q;
    logic                  busy_q;
    logic                  mem_wr_en_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wr_data_q;
    logic                  c_ack_q, c_err_q, d_ack_q, d_err_q;
    logic [DATA_WIDTH-1:0] c_rdata_q, d_rdata_q;

    logic                  any_req;
    logic                  pick_d;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_err;

    assign any_req   = c_req | d_req;
    assign pick_d    = d_req & (~c_req | ptr_q);
    assign sel_we    = pick_d ? d_we    : c_we;
    assign sel_addr  = pick_d ? d_addr  : c_addr;
    assign sel_wdata = pick_d ? d_wdata : c_wdata;
    assign sel_err   = (sel_addr < DMEM_BASE) || (sel_addr[1:0] != 2'b00);

    // Memory-side outputs are registered so a rejected access never reaches the memory pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= 1'b0;
            port_q        <= 1'b0;
            we_q          <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            c_ack_q       <= 1'b0;
            c_err_q       <= 1'b0;
            c_rdata_q     <= '0;
            d_ack_q       <= 1'b0;
            d_err_q       <= 1'b0;
            d_rdata_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        port_q        <= pick_d;
                        we_q          <= sel_we;
                        err_q         <= sel_err;
                        ptr_q         <= ~pick_d;
                        busy_q        <= 1'b1;
                        mem_wr_en_q   <= sel_we & ~sel_err;
                        mem_addr_q    <= sel_err ? '0 : sel_addr;
                        mem_wr_data_q <= sel_err ? '0 : sel_wdata;
                        state_q       <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_wr_en_q   <= 1'b0;
                    mem_addr_q    <= '0;
                    mem_wr_data_q <= '0;
                    if (port_q) begin
                        d_ack_q   <= 1'b1;
                        d_err_q   <= err_q;
                        d_rdata_q <= (!we_q && !err_q) ? mem_rd_data : '0;
                    end else begin
                        c_ack_q   <= 1'b1;
                        c_err_q   <= err_q;
                        c_rdata_q <= (!we_q && !err_q) ? mem_rd_data : '0;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    c_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign c_ack       = c_ack_q;
    assign c_err       = c_err_q;
    assign c_rdata     = c_rdata_q;
    assign d_ack       = d_ack_q;
    assign d_err       = d_err_q;
    assign d_rdata     = d_rdata_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_data = mem_wr_data_q;
    assign busy        = busy_q;
    assign dbg_state   = state_q;

`ifdef DMEM_ARB_PERF_EN
    logic [15:0] perf_c_q, perf_d_q, perf_conf_q;
    logic        in_idle;

    assign in_idle = (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_c_q    <= '0;
            perf_d_q    <= '0;
            perf_conf_q <= '0;
        end else if (perf_clr) begin
            perf_c_q    <= '0;
            perf_d_q    <= '0;
            perf_conf_q <= '0;
        end else begin
            if (in_idle && c_req && !pick_d && perf_c_q != 16'hFFFF)
                perf_c_q <= perf_c_q + 16'd1;
            if (in_idle && pick_d && perf_d_q != 16'hFFFF)
                perf_d_q <= perf_d_q + 16'd1;
            if (in_idle && c_req && d_req && perf_conf_q != 16'hFFFF)
                perf_conf_q <= perf_conf_q + 16'd1;
        end
    end

    assign perf_c_grants  = perf_c_q;
    assign perf_d_grants  = perf_d_q;
    assign perf_conflicts = perf_conf_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed and random transactions on both ports, checked cycle by
// cycle against a transaction-level model of arbitration order, timing and memory contents.
module tb_dmem_arbiter;

    localparam logic [31:0] BASE = 32'h02000000;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_ack, c_err, d_ack, d_err;
    logic [31:0] c_rdata, d_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
    logic        busy;
    logic [1:0]  dbg_state;
`ifdef DMEM_ARB_PERF_EN
    logic        perf_clr;
    logic [15:0] perf_c_grants, perf_d_grants, perf_conflicts;
`endif

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_err(c_err), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .busy(busy),
`ifdef DMEM_ARB_PERF_EN
        .perf_clr(perf_clr), .perf_c_grants(perf_c_grants),
        .perf_d_grants(perf_d_grants), .perf_conflicts(perf_conflicts),
`endif
        .dbg_state(dbg_state)
    );

    // Memory stand-in: 256 words, combinational read, write on the clock edge.
    logic [31:0] mem [0:255];
    logic        tb_fill;
    assign mem_rd_data = mem[mem_addr[9:2]];

    function automatic logic [31:0] fill_val(int i);
        return 32'(i) * 32'h9E3779B9 + 32'h1234;
    endfunction

    always @(posedge clk) begin
        if (tb_fill) begin
            for (int i = 0; i < 256; i++) mem[i] <= fill_val(i);
        end else if (mem_wr_en) begin
            mem[mem_addr[9:2]] <= mem_wr_data;
        end
    end

    // Reference model state
    logic [31:0] model_mem [0:255];
    txn_t        c_txq[$], d_txq[$];
    bit          c_pend, d_pend;
    bit          have_txn, g_port, last_d;
    int          cyc, free_at, g_cyc;
    logic        g_we, g_err;
    logic [31:0] g_addr, g_wdata;
    logic [31:0] exp_c_rdata, exp_d_rdata;
    logic        exp_c_err, exp_d_err;
    int          n_c_grants, n_d_grants, n_conflicts;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk1(string tag, logic obs, logic exp);
        chk(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    function automatic txn_t gen();
        txn_t t;
        int   kind;
        kind    = int'($urandom_range(0, 9));
        t.we    = 1'($urandom_range(0, 1));
        t.wdata = $urandom;
        t.addr  = BASE + 32'($urandom_range(0, 63)) * 32'd4;
        if (kind == 0)
            t.addr = 32'($urandom_range(0, 32'h01FFFFFF)) & ~32'h3;
        else if (kind == 1)
            t.addr = BASE + 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(1, 3));
        return t;
    endfunction

    task automatic load_ports();
        txn_t t;
        if (!c_pend && c_txq.size() > 0) begin
            t = c_txq.pop_front();
            c_req = 1'b1; c_we = t.we; c_addr = t.addr; c_wdata = t.wdata; c_pend = 1'b1;
        end else if (!c_pend) begin
            c_req = 1'b0; c_we = 1'($urandom_range(0, 1)); c_addr = $urandom; c_wdata = $urandom;
        end
        if (!d_pend && d_txq.size() > 0) begin
            t = d_txq.pop_front();
            d_req = 1'b1; d_we = t.we; d_addr = t.addr; d_wdata = t.wdata; d_pend = 1'b1;
        end else if (!d_pend) begin
            d_req = 1'b0; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
        end
    endtask

    // Idle arbiter takes a request; on a conflict the port not served last wins.
    task automatic arbitrate();
        if (!have_txn && cyc >= free_at && (c_req || d_req)) begin
            if (c_req && d_req) begin
                n_conflicts++;
                g_port = !last_d;
            end else begin
                g_port = d_req;
            end
            g_we    = g_port ? d_we    : c_we;
            g_addr  = g_port ? d_addr  : c_addr;
            g_wdata = g_port ? d_wdata : c_wdata;
            g_err   = (g_addr < BASE) || (g_addr[1:0] != 2'b00);
            if (g_port) n_d_grants++; else n_c_grants++;
            last_d   = g_port;
            have_txn = 1'b1;
            g_cyc    = cyc;
            free_at  = cyc + 3;
        end
    endtask

    task automatic step();
        bit acc, rsp;
        @(negedge clk);
        cyc++;
        acc = have_txn && (cyc == g_cyc + 1);
        rsp = have_txn && (cyc == g_cyc + 2);
        chk1("busy", busy, acc || rsp);
        chk1("mem_wr_en", mem_wr_en, acc && g_we && !g_err);
        chk("mem_addr", mem_addr, (acc && !g_err) ? g_addr : 32'h0);
        if (acc && g_we && !g_err) chk("mem_wr_data", mem_wr_data, g_wdata);
        if (rsp) begin
            if (g_port) begin
                exp_d_err   = g_err;
                exp_d_rdata = (!g_we && !g_err) ? model_mem[g_addr[9:2]] : 32'h0;
            end else begin
                exp_c_err   = g_err;
                exp_c_rdata = (!g_we && !g_err) ? model_mem[g_addr[9:2]] : 32'h0;
            end
            if (g_we && !g_err) model_mem[g_addr[9:2]] = g_wdata;
        end
        chk1("c_ack", c_ack, rsp && !g_port);
        chk1("d_ack", d_ack, rsp && g_port);
        chk1("c_err", c_err, exp_c_err);
        chk1("d_err", d_err, exp_d_err);
        chk("c_rdata", c_rdata, exp_c_rdata);
        chk("d_rdata", d_rdata, exp_d_rdata);
        if (rsp) begin
            have_txn = 1'b0;
            if (g_port) d_pend = 1'b0; else c_pend = 1'b0;
        end
        load_ports();
        arbitrate();
    endtask

    task automatic start_phase();
        load_ports();
        arbitrate();
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((c_txq.size() > 0 || d_txq.size() > 0 || c_pend || d_pend || have_txn)
               && n < budget) begin
            step();
            n++;
        end
        chk1("drain_done", n < budget, 1'b1);
    endtask

    task automatic run_one(bit port_d, logic we, logic [31:0] addr, logic [31:0] wdata);
        if (port_d) d_txq.push_back('{we, addr, wdata});
        else        c_txq.push_back('{we, addr, wdata});
        start_phase();
        drain(20);
    endtask

    task automatic model_reset();
        have_txn = 1'b0; c_pend = 1'b0; d_pend = 1'b0; last_d = 1'b1;
        c_req = 1'b0; d_req = 1'b0;
        exp_c_rdata = '0; exp_d_rdata = '0; exp_c_err = 1'b0; exp_d_err = 1'b0;
        n_c_grants = 0; n_d_grants = 0; n_conflicts = 0;
        cyc = 0; free_at = 0; g_cyc = -10;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old_word;
        rst_n = 1'b0;
        tb_fill = 1'b1;
        c_we = 1'b0; c_addr = '0; c_wdata = '0;
        d_we = 1'b0; d_addr = '0; d_wdata = '0;
`ifdef DMEM_ARB_PERF_EN
        perf_clr = 1'b0;
`endif
        for (int i = 0; i < 256; i++) model_mem[i] = fill_val(i);
        model_reset();
        repeat (3) @(negedge clk);

        chk1("rst_c_ack", c_ack, 1'b0);
        chk1("rst_d_ack", d_ack, 1'b0);
        chk1("rst_c_err", c_err, 1'b0);
        chk1("rst_d_err", d_err, 1'b0);
        chk("rst_c_rdata", c_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk1("rst_mem_wr_en", mem_wr_en, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk1("rst_busy", busy, 1'b0);
        tb_fill = 1'b0;
        rst_n = 1'b1;

        // Directed: write/read-back, out-of-window, misaligned, window boundary
        run_one(1'b0, 1'b1, 32'h02000010, 32'hDEADBEEF);
        run_one(1'b0, 1'b0, 32'h02000010, 32'h0);
        run_one(1'b1, 1'b1, 32'h00001000, 32'hCAFEF00D);
        run_one(1'b0, 1'b0, 32'h02000002, 32'h0);
        run_one(1'b1, 1'b0, BASE - 32'd4, 32'h0);
        run_one(1'b0, 1'b0, BASE, 32'h0);

        // Contention 4+4, then random bursts with idle gaps
        for (int i = 0; i < 4; i++) begin
            c_txq.push_back(gen());
            d_txq.push_back(gen());
        end
        start_phase();
        drain(60);
        for (int r = 0; r < 15; r++) begin
            int nc, nd;
            nc = int'($urandom_range(0, 3));
            nd = int'($urandom_range(0, 3));
            for (int i = 0; i < nc; i++) c_txq.push_back(gen());
            for (int i = 0; i < nd; i++) d_txq.push_back(gen());
            start_phase();
            drain(60);
            repeat ($urandom_range(0, 2)) step();
        end

        // Reset during ACCESS: write must not commit and must not be acknowledged
        old_word = model_mem[5];
        c_txq.push_back('{1'b1, BASE + 32'd20, ~old_word});
        start_phase();
        step();
        #1 rst_n = 1'b0;
        #1;
        chk1("abort_mem_wr_en", mem_wr_en, 1'b0);
        chk("abort_mem_addr", mem_addr, 32'h0);
        chk1("abort_busy", busy, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();

        // Post-reset contention: C preferred first; C's first access reads the aborted word
        c_txq.push_back('{1'b0, BASE + 32'd20, 32'h0});
        for (int i = 0; i < 3; i++) c_txq.push_back(gen());
        for (int i = 0; i < 4; i++) d_txq.push_back(gen());
        start_phase();
        drain(60);
        chk("aborted_word_kept", model_mem[5], old_word);
`ifdef DMEM_ARB_PERF_EN
        chk("perf_c_grants", {16'h0, perf_c_grants}, 32'(n_c_grants));
        chk("perf_d_grants", {16'h0, perf_d_grants}, 32'(n_d_grants));
        chk("perf_conflicts", {16'h0, perf_conflicts}, 32'(n_conflicts));
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        chk("perf_c_clr", {16'h0, perf_c_grants}, 32'h0);
        chk("perf_d_clr", {16'h0, perf_d_grants}, 32'h0);
        chk("perf_conf_clr", {16'h0, perf_conflicts}, 32'h0);
`endif
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
